// File: rtl/router.sv
// 5-port mesh NoC router: four 64-bit neighbour ports plus one 40-bit local PE port.
// Dimension-ordered (X then Y) routing; one-entry buffer per input, one-entry register per output.
// Optional macro ROUTER_RR_ARB_EN selects per-output round-robin arbitration; otherwise fixed
// priority local > up > down > left > right.
module router #(
  parameter logic [3:0]  LOCAL_ADDR     = 4'b0000,
  parameter int unsigned PACK_WIDTH     = 64,
  parameter int unsigned PACKET_D_WIDTH = 40
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PACK_WIDTH-1:0]     in_up_data,
  input  logic                      in_up_valid,
  output logic                      in_up_ready,
  input  logic [PACK_WIDTH-1:0]     in_down_data,
  input  logic                      in_down_valid,
  output logic                      in_down_ready,
  input  logic [PACK_WIDTH-1:0]     in_left_data,
  input  logic                      in_left_valid,
  output logic                      in_left_ready,
  input  logic [PACK_WIDTH-1:0]     in_right_data,
  input  logic                      in_right_valid,
  output logic                      in_right_ready,
  input  logic [PACKET_D_WIDTH-1:0] in_local_data,
  input  logic                      in_local_valid,
  output logic                      in_local_ready,
  output logic [PACK_WIDTH-1:0]     out_up_data,
  output logic                      out_up_valid,
  input  logic                      out_up_ready,
  output logic [PACK_WIDTH-1:0]     out_down_data,
  output logic                      out_down_valid,
  input  logic                      out_down_ready,
  output logic [PACK_WIDTH-1:0]     out_left_data,
  output logic                      out_left_valid,
  input  logic                      out_left_ready,
  output logic [PACK_WIDTH-1:0]     out_right_data,
  output logic                      out_right_valid,
  input  logic                      out_right_ready,
  output logic [PACKET_D_WIDTH-1:0] router_out1_data,
  output logic                      router_out1_valid,
  input  logic                      router_out1_ready,
  output logic [PACKET_D_WIDTH-1:0] router_out2_data,
  output logic                      router_out2_valid,
  input  logic                      router_out2_ready
);

  // Input index order: local, up, down, left, right (also the round-robin order).
  localparam int NumIn  = 5;
  localparam int NumNb  = 4;
  localparam int NumOut = 6;
  // Output indices.
  localparam int OutUp    = 0;
  localparam int OutDown  = 1;
  localparam int OutLeft  = 2;
  localparam int OutRight = 3;
  localparam int OutLoc1  = 4;
  localparam int OutLoc2  = 5;

  logic [PACK_WIDTH-1:0]     in_pkt [NumIn];
  logic [NumIn-1:0]          in_valid;
  logic [NumIn-1:0]          in_ready;
  logic [PACK_WIDTH-1:0]     buf_data_q [NumIn];
  logic [NumIn-1:0]          buf_valid_q;
  logic [2:0]                buf_route [NumIn];
  logic [NumIn-1:0]          req [NumOut];
  logic [NumOut-1:0]         out_valid_q;
  logic [NumOut-1:0]         out_ready;
  logic [NumOut-1:0]         can_load;
  logic [PACK_WIDTH-1:0]     nb_data_q [NumNb];
  logic [PACKET_D_WIDTH-1:0] loc_data_q [2];
  logic [NumOut-1:0]         gnt_any;
  logic [2:0]                gnt_idx [NumOut];
  logic [NumIn-1:0]          in_taken;

`ifdef ROUTER_RR_ARB_EN
  logic [2:0] rr_ptr_q [NumOut];
`endif

  // X first, then Y, then local delivery split by packet type.
  function automatic logic [2:0] route_pkt(input logic [3:0] dest, input logic [2:0] ptype);
    logic [1:0] dx, dy, lx, ly;
    dx = dest[3:2];
    dy = dest[1:0];
    lx = LOCAL_ADDR[3:2];
    ly = LOCAL_ADDR[1:0];
    if (dx > lx)              return 3'(OutRight);
    else if (dx < lx)         return 3'(OutLeft);
    else if (dy > ly)         return 3'(OutUp);
    else if (dy < ly)         return 3'(OutDown);
    else if (ptype == 3'b000) return 3'(OutLoc1);
    else                      return 3'(OutLoc2);
  endfunction

  // Local ingress is wrapped into the neighbour packet format with this node as source.
  assign in_pkt[0] = {in_local_data[39:36], LOCAL_ADDR, in_local_data[35:33], 13'b0, 7'b0,
                      in_local_data[32:0]};
  assign in_pkt[1] = in_up_data;
  assign in_pkt[2] = in_down_data;
  assign in_pkt[3] = in_left_data;
  assign in_pkt[4] = in_right_data;

  assign in_valid = {in_right_valid, in_left_valid, in_down_valid, in_up_valid, in_local_valid};
  assign in_ready = ~buf_valid_q;

  assign in_local_ready = in_ready[0];
  assign in_up_ready    = in_ready[1];
  assign in_down_ready  = in_ready[2];
  assign in_left_ready  = in_ready[3];
  assign in_right_ready = in_ready[4];

  assign out_ready = {router_out2_ready, router_out1_ready, out_right_ready, out_left_ready,
                      out_down_ready, out_up_ready};
  // An output accepts a new packet when empty or when its current one leaves this edge.
  assign can_load  = ~out_valid_q | out_ready;

  // Route decision and per-output request vectors from the buffered packets.
  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      buf_route[i] = route_pkt(buf_data_q[i][63:60], buf_data_q[i][55:53]);
    end
    for (int o = 0; o < NumOut; o++) begin
      for (int i = 0; i < NumIn; i++) begin
        req[o][i] = buf_valid_q[i] && (buf_route[i] == 3'(o));
      end
    end
  end

  // Per-output arbitration; each input requests exactly one output so grants never collide.
  always_comb begin
    int idx;
    idx      = 0;
    gnt_any  = '0;
    in_taken = '0;
    for (int o = 0; o < NumOut; o++) begin
      gnt_idx[o] = '0;
      if (can_load[o]) begin
        for (int k = 0; k < NumIn; k++) begin
`ifdef ROUTER_RR_ARB_EN
          idx = int'(rr_ptr_q[o]) + k;
          if (idx >= NumIn) idx = idx - NumIn;
`else
          idx = k;
`endif
          if (!gnt_any[o] && req[o][idx]) begin
            gnt_any[o] = 1'b1;
            gnt_idx[o] = 3'(idx);
          end
        end
      end
      if (gnt_any[o]) in_taken[gnt_idx[o]] = 1'b1;
    end
  end

  // Input buffers: fill on handshake, clear when moved into an output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= '0;
      for (int i = 0; i < NumIn; i++) buf_data_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumIn; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          buf_valid_q[i] <= 1'b1;
          buf_data_q[i]  <= in_pkt[i];
        end else if (in_taken[i]) begin
          buf_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Output registers: hold until ready, reload on the same edge they drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      for (int o = 0; o < NumNb; o++) nb_data_q[o] <= '0;
      for (int l = 0; l < 2; l++) loc_data_q[l] <= '0;
    end else begin
      for (int o = 0; o < NumOut; o++) begin
        if (gnt_any[o])        out_valid_q[o] <= 1'b1;
        else if (out_ready[o]) out_valid_q[o] <= 1'b0;
      end
      for (int o = 0; o < NumNb; o++) begin
        if (gnt_any[o]) nb_data_q[o] <= buf_data_q[gnt_idx[o]];
      end
      for (int l = 0; l < 2; l++) begin
        if (gnt_any[OutLoc1+l]) begin
          loc_data_q[l] <= buf_data_q[gnt_idx[OutLoc1+l]][PACKET_D_WIDTH-1:0];
        end
      end
    end
  end

`ifdef ROUTER_RR_ARB_EN
  // Round-robin pointer moves to one past the input just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < NumOut; o++) rr_ptr_q[o] <= '0;
    end else begin
      for (int o = 0; o < NumOut; o++) begin
        if (gnt_any[o]) begin
          rr_ptr_q[o] <= (gnt_idx[o] == 3'(NumIn - 1)) ? 3'd0 : gnt_idx[o] + 3'd1;
        end
      end
    end
  end
`endif

  assign out_up_data       = nb_data_q[OutUp];
  assign out_down_data     = nb_data_q[OutDown];
  assign out_left_data     = nb_data_q[OutLeft];
  assign out_right_data    = nb_data_q[OutRight];
  assign router_out1_data  = loc_data_q[0];
  assign router_out2_data  = loc_data_q[1];
  assign out_up_valid      = out_valid_q[OutUp];
  assign out_down_valid    = out_valid_q[OutDown];
  assign out_left_valid    = out_valid_q[OutLeft];
  assign out_right_valid   = out_valid_q[OutRight];
  assign router_out1_valid = out_valid_q[OutLoc1];
  assign router_out2_valid = out_valid_q[OutLoc2];

endmodule

// File: tb/tb_router.sv
// Self-checking bench for router at LOCAL_ADDR=4'b1000: directed cases plus randomized traffic
// checked by a scoreboard of expected (input, output, word) transfers.
module tb_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] loc_in;
  logic [63:0] nb_in [4];   // up, down, left, right
  logic [4:0]  iv, ir;      // local, up, down, left, right
  logic [5:0]  ov, ordy;    // up, down, left, right, out1, out2
  logic [63:0] o_up, o_down, o_left, o_right;
  logic [39:0] o_l1, o_l2;

  int checks = 0;
  int errors = 0;
  int unsigned seq = 0;

  typedef struct {
    int          src;
    int          dst;
    logic [63:0] w;
  } ent_t;
  ent_t sb [$];

  always #5 clk = ~clk;

  router #(.LOCAL_ADDR(4'b1000), .PACK_WIDTH(64), .PACKET_D_WIDTH(40)) dut (
    .clk(clk), .rst(rst),
    .in_up_data(nb_in[0]),    .in_up_valid(iv[1]),    .in_up_ready(ir[1]),
    .in_down_data(nb_in[1]),  .in_down_valid(iv[2]),  .in_down_ready(ir[2]),
    .in_left_data(nb_in[2]),  .in_left_valid(iv[3]),  .in_left_ready(ir[3]),
    .in_right_data(nb_in[3]), .in_right_valid(iv[4]), .in_right_ready(ir[4]),
    .in_local_data(loc_in),   .in_local_valid(iv[0]), .in_local_ready(ir[0]),
    .out_up_data(o_up),       .out_up_valid(ov[0]),   .out_up_ready(ordy[0]),
    .out_down_data(o_down),   .out_down_valid(ov[1]), .out_down_ready(ordy[1]),
    .out_left_data(o_left),   .out_left_valid(ov[2]), .out_left_ready(ordy[2]),
    .out_right_data(o_right), .out_right_valid(ov[3]), .out_right_ready(ordy[3]),
    .router_out1_data(o_l1),  .router_out1_valid(ov[4]), .router_out1_ready(ordy[4]),
    .router_out2_data(o_l2),  .router_out2_valid(ov[5]), .router_out2_ready(ordy[5])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Destination output from the addressing rules: x compared first, then y, then type.
  function automatic int route_of(input logic [63:0] w);
    int dx, dy;
    dx = int'(w[63:62]);
    dy = int'(w[61:60]);
    if (dx > 2) return 3;
    if (dx < 2) return 2;
    if (dy > 0) return 0;
    if (dy < 0) return 1;
    return (w[55:53] == 3'b000) ? 4 : 5;
  endfunction

  function automatic logic [63:0] in_word(input int i);
    if (i == 0) return {loc_in[39:36], 4'b1000, loc_in[35:33], 20'b0, loc_in[32:0]};
    return nb_in[i-1];
  endfunction

  function automatic logic [63:0] get_od(input int o);
    case (o)
      0:       return o_up;
      1:       return o_down;
      2:       return o_left;
      3:       return o_right;
      4:       return {24'b0, o_l1};
      default: return {24'b0, o_l2};
    endcase
  endfunction

  task automatic set_input(input int i, input logic [3:0] d, input logic [2:0] t,
                           input logic [39:0] data);
    if (i == 0) loc_in = {d, t, data[32:0]};
    else        nb_in[i-1] = {d, 4'($urandom), t, 13'b0, data};
  endtask

  // Raise valid on every input in mask and hold each until its handshake.
  task automatic send(input logic [4:0] mask);
    logic [4:0] pend, done;
    pend = mask;
    iv   = iv | mask;
    for (int c = 0; c < 50 && pend != 0; c++) begin
      @(negedge clk);
      done = pend & ir;
      @(posedge clk);
      #1;
      iv   = iv & ~done;
      pend = pend & ~done;
    end
    checks++;
    if (pend != 0) begin
      errors++;
      $display("FAIL send_timeout actual=%b expected=%b", pend, 5'b0);
      iv = iv & ~pend;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: record accepted inputs, match every output transfer, check holds.
  logic [5:0]  pv, pr;
  logic [63:0] pd [6];
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      pv = '0;
    end else begin
      for (int o = 0; o < 6; o++) begin
        if (pv[o] && !pr[o]) begin
          chk($sformatf("hold_valid_o%0d", o), 64'(ov[o]), 64'd1);
          chk($sformatf("hold_data_o%0d", o), get_od(o), pd[o]);
        end
        if (ov[o] && ordy[o]) begin : match
          int k;
          bit order_ok;
          k = -1;
          order_ok = 1'b1;
          for (int j = 0; j < sb.size(); j++) begin
            if (sb[j].dst == o && sb[j].w == get_od(o)) begin
              k = j;
              break;
            end
          end
          if (k >= 0) begin
            for (int j = 0; j < k; j++) begin
              if (sb[j].dst == o && sb[j].src == sb[k].src) order_ok = 1'b0;
            end
          end
          checks++;
          if (k < 0 || !order_ok) begin
            errors++;
            $display("FAIL deliver_o%0d actual=%h expected=%s", o, get_od(o),
                     (k < 0) ? "a pending packet" : "in-order packet");
          end
          if (k >= 0) sb.delete(k);
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (iv[i] && ir[i]) begin : rec
          ent_t e;
          e.src = i;
          e.dst = route_of(in_word(i));
          e.w   = (e.dst >= 4) ? {24'b0, in_word(i)[39:0]} : in_word(i);
          sb.push_back(e);
        end
      end
      pv = ov;
      pr = ordy;
      for (int o = 0; o < 6; o++) pd[o] = get_od(o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a_word, b_word;
    logic [4:0]  fire;
    rst    = 1'b0;
    iv     = '0;
    ordy   = '1;
    loc_in = '0;
    for (int i = 0; i < 4; i++) nb_in[i] = '0;
    #1 rst = 1'b1;
    tick(3);

    // Model pins.
    chk("model_route_left", 64'(route_of({4'b0001, 60'b0})), 64'd2);
    chk("model_route_up", 64'(route_of({4'b1011, 60'b0})), 64'd0);
    chk("model_route_out2", 64'(route_of({4'b1000, 4'b0, 3'b001, 53'b0})), 64'd5);

    // Reset values.
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_in_ready", 64'(ir), 64'h1f);
    for (int o = 0; o < 6; o++) chk($sformatf("rst_data_o%0d", o), get_od(o), 64'd0);
    rst = 1'b0;
    tick(1);

    // Local delivery, type 0 -> out1 with two-edge latency.
    set_input(1, 4'b1000, 3'b000, 40'h12_3456_789A);
    send(5'b00010);
    chk("t1_out1_not_yet", 64'(ov[4]), 64'd0);
    chk("t1_up_ready_low", 64'(ir[1]), 64'd0);
    tick(1);
    chk("t1_out1_valid", 64'(ov[4]), 64'd1);
    chk("t1_out1_data", {24'b0, o_l1}, 64'h12_3456_789A);
    chk("t1_out2_idle", 64'(ov[5]), 64'd0);
    tick(3);

    // Local delivery, nonzero type -> out2.
    set_input(1, 4'b1000, 3'b001, 40'hAB);
    send(5'b00010);
    tick(1);
    chk("t2_out2_valid", 64'(ov[5]), 64'd1);
    chk("t2_out2_data", {24'b0, o_l2}, 64'hAB);
    chk("t2_out1_idle", 64'(ov[4]), 64'd0);
    tick(3);

    // Neighbour forwarding from down.
    begin
      logic [3:0] dests [3];
      int         outs [3];
      dests[0] = 4'b0001; outs[0] = 2;
      dests[1] = 4'b1101; outs[1] = 3;
      dests[2] = 4'b1011; outs[2] = 0;
      for (int n = 0; n < 3; n++) begin
        set_input(2, dests[n], 3'($urandom), 40'($urandom));
        send(5'b00100);
        tick(1);
        chk($sformatf("t3_valid_%0d", n), 64'(ov[outs[n]]), 64'd1);
        chk($sformatf("t3_data_%0d", n), get_od(outs[n]), nb_in[1]);
        tick(2);
      end
    end
    set_input(0, 4'b1000, 3'b000, 40'h1_2345_6789);
    send(5'b00001);
    tick(1);
    chk("t3_local_out1", {24'b0, o_l1}, 64'h01_2345_6789);
    tick(3);

    // Contention on out_left: up wins first, down follows on the next transfer.
    set_input(1, 4'b0001, 3'b000, 40'h11);
    set_input(2, 4'b0001, 3'b000, 40'h22);
    send(5'b00110);
    tick(1);
    chk("t4_first_up", o_left, nb_in[0]);
    tick(1);
    chk("t4_second_down", o_left, nb_in[1]);
    tick(3);

    // Backpressure on out_left.
    ordy[2] = 1'b0;
    set_input(1, 4'b0001, 3'b010, 40'h33);
    a_word = nb_in[0];
    send(5'b00010);
    set_input(1, 4'b0001, 3'b011, 40'h44);
    b_word = nb_in[0];
    send(5'b00010);
    for (int c = 0; c < 10; c++) begin
      tick(1);
      chk("t5_stall_data", o_left, a_word);
      chk("t5_up_ready_low", 64'(ir[1]), 64'd0);
    end
    ordy[2] = 1'b1;
    tick(1);
    chk("t5_release_next", o_left, b_word);
    tick(3);

    // Reset in the middle of a stalled transfer.
    ordy[2] = 1'b0;
    set_input(1, 4'b0001, 3'b000, 40'h55);
    send(5'b00010);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_valids_cleared", 64'(ov), 64'd0);
    chk("t6_readies_set", 64'(ir), 64'h1f);
    @(posedge clk);
    #1 rst = 1'b0;
    ordy = '1;
    set_input(1, 4'b1011, 3'b101, 40'h66);
    send(5'b00010);
    tick(1);
    chk("t6_after_reset_up", o_up, nb_in[0]);
    tick(3);

    // Randomized traffic with random back-pressure.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      fire = iv & ir;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
        if (fire[i]) iv[i] = 1'b0;
        if (!iv[i] && ($urandom % 2 == 0)) begin
          seq++;
          set_input(i, 4'($urandom), ($urandom % 2 == 0) ? 3'b000 : 3'($urandom),
                    {7'b0, seq[15:0], 17'($urandom)});
          iv[i] = 1'b1;
        end
      end
      for (int o = 0; o < 6; o++) ordy[o] = ($urandom % 4 != 0);
    end

    // Drain: hold pending valids to their handshake, then wait for the scoreboard to empty.
    ordy = '1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      fire = iv & ir;
      @(posedge clk);
      #1;
      iv = iv & ~fire;
      if (iv == 0 && sb.size() == 0) break;
    end
    chk("drain_pending_inputs", 64'(iv), 64'd0);
    chk("drain_scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
